// File: rtl/ks_note_sequencer.sv
`default_nettype none
// ============================================================================
// ks_note_sequencer : steps a small note table and drives ks_string inputs
// Rev 1.0
// ============================================================================
module ks_note_sequencer #(
    parameter int NUM_STEPS   = 8,
    parameter int STEP_AW     = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int PLUCK_TICKS = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  tick_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  loop_en_i,
    input  logic [STEP_AW-1:0]    last_step_i,
    input  logic                  tbl_we_i,
    input  logic [STEP_AW+1:0]    tbl_addr_i,
    input  logic [DATA_WIDTH-1:0] tbl_wdata_i,
    output logic [DATA_WIDTH-1:0] period_o,
    output logic [DATA_WIDTH-1:0] dynamics_R_o,
    output logic                  pluck_o,
    output logic                  busy_o,
    output logic [STEP_AW-1:0]    step_o,
    output logic                  done_o
);

    localparam int PW = $clog2(PLUCK_TICKS + 1);
    localparam logic [PW-1:0]         C_PLUCK = PW'(PLUCK_TICKS);
    localparam logic [DATA_WIDTH-1:0] C_ONE   = DATA_WIDTH'(1);
    localparam logic [STEP_AW-1:0]    C_STEP1 = STEP_AW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        NOTE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [STEP_AW-1:0]      step_q, step_d;
    logic [DATA_WIDTH-1:0]   period_q, period_d;
    logic [DATA_WIDTH-1:0]   dyn_q, dyn_d;
    logic [DATA_WIDTH-1:0]   dur_cnt_q, dur_cnt_d;
    logic [PW-1:0]           pluck_cnt_q, pluck_cnt_d;
    logic                    pluck_q, pluck_d;
    logic                    done_q, done_d;

    logic [DATA_WIDTH-1:0]   tbl_period_q [NUM_STEPS];
    logic [DATA_WIDTH-1:0]   tbl_dyn_q    [NUM_STEPS];
    logic [DATA_WIDTH-1:0]   tbl_dur_q    [NUM_STEPS];
    logic                    tbl_rest_q   [NUM_STEPS];

    logic [STEP_AW-1:0]      wr_step;
    logic [1:0]              wr_field;

    assign wr_step  = tbl_addr_i[STEP_AW+1:2];
    assign wr_field = tbl_addr_i[1:0];

    // Only bit0 of the flags byte (rest) has any effect, so only it is stored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                tbl_period_q[i] <= '0;
                tbl_dyn_q[i]    <= '0;
                tbl_dur_q[i]    <= '0;
                tbl_rest_q[i]   <= 1'b0;
            end
        end else if (tbl_we_i) begin
            case (wr_field)
                2'd0:    tbl_period_q[wr_step] <= tbl_wdata_i;
                2'd1:    tbl_dyn_q[wr_step]    <= tbl_wdata_i;
                2'd2:    tbl_dur_q[wr_step]    <= tbl_wdata_i;
                default: tbl_rest_q[wr_step]   <= tbl_wdata_i[0];
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            step_q      <= '0;
            period_q    <= '0;
            dyn_q       <= '0;
            dur_cnt_q   <= '0;
            pluck_cnt_q <= '0;
            pluck_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            period_q    <= period_d;
            dyn_q       <= dyn_d;
            dur_cnt_q   <= dur_cnt_d;
            pluck_cnt_q <= pluck_cnt_d;
            pluck_q     <= pluck_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        period_d    = period_q;
        dyn_d       = dyn_q;
        dur_cnt_d   = dur_cnt_q;
        pluck_cnt_d = pluck_cnt_q;
        pluck_d     = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                    step_d  = '0;
                end
            end
            LOAD: begin
                period_d    = tbl_period_q[step_q];
                dyn_d       = tbl_dyn_q[step_q];
                dur_cnt_d   = (tbl_dur_q[step_q] == '0) ? C_ONE : tbl_dur_q[step_q];
                pluck_cnt_d = tbl_rest_q[step_q] ? '0 : C_PLUCK;
                state_d     = NOTE;
            end
            NOTE: begin
                if (tick_i) begin
                    if (pluck_cnt_q != '0) begin
                        pluck_cnt_d = pluck_cnt_q - 1'b1;
                    end
                    if (dur_cnt_q == C_ONE) begin
                        if (step_q < last_step_i) begin
                            step_d  = step_q + C_STEP1;
                            state_d = LOAD;
                        end else if (loop_en_i) begin
                            step_d  = '0;
                            state_d = LOAD;
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        dur_cnt_d = dur_cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (stop_i) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end

        // Registered pluck: low in LOAD so each played note gives a fresh edge.
        pluck_d = (state_d == NOTE) && (pluck_cnt_d != '0);
    end

    assign period_o     = period_q;
    assign dynamics_R_o = dyn_q;
    assign pluck_o      = pluck_q;
    assign busy_o       = (state_q != IDLE);
    assign step_o       = step_q;
    assign done_o       = done_q;

endmodule
`default_nettype wire
